// File: rtl/led_mode_ctrl_if.sv
// led_mode_ctrl_if: front-panel bundle of raw keys/switches in, LED drive and mode out.
// The controller takes the slave side; the board top level (or a bench) drives master.
interface led_mode_ctrl_if;
  logic [3:0] key;
  logic [3:0] sw;
  logic [7:0] led;
  logic [1:0] mode;

  modport master (
    output key,
    output sw,
    input  led,
    input  mode
  );

  modport slave (
    input  key,
    input  sw,
    output led,
    output mode
  );
endinterface

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: synchronises and debounces four push keys, turns presses into commands
// and drives eight LEDs in one of four modes (static, running light, blink, binary count).
// Build option: define LED_DEBOUNCE_EN to build the per-key debounce counters; when it is
// undefined the synchronised keys are taken as the stable key state directly.
module led_mode_ctrl #(
  parameter int unsigned DEB_CYCLES     = 240000,
  parameter int unsigned TICK_CYCLES    = 3000000,
  parameter int unsigned KEY_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  led_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StStatic = 2'd0,
    StRun    = 2'd1,
    StBlink  = 2'd2,
    StCount  = 2'd3
  } mode_e;

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic [3:0] kp_raw;
  logic [3:0] key_meta_q;
  logic [3:0] kp_q;
  logic [3:0] sw_meta_q;
  logic [3:0] sw_sync_q;

  // Keys are normalised to 1 = pressed before the synchroniser, so its reset value of 0
  // means "released" whatever the key polarity.
  assign kp_raw = (KEY_ACTIVE_LOW != 0) ? ~bus.key : bus.key;

  // Two-flop synchronisers for keys and switches
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_q <= '0;
      kp_q       <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      key_meta_q <= kp_raw;
      kp_q       <= key_meta_q;
      sw_meta_q  <= bus.sw;
      sw_sync_q  <= sw_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: kst is the accepted (stable) key state
  // ---------------------------------------------------------------------------
  logic [3:0] kst;

`ifdef LED_DEBOUNCE_EN
  localparam int unsigned DebW = (DEB_CYCLES > 0) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES);

  logic [3:0]      kst_q;
  logic [3:0]      kst_d;
  logic [DebW-1:0] deb_cnt_q [4];
  logic [DebW-1:0] deb_cnt_d [4];

  // Per-key counter: runs while the synchronised key disagrees with the stable state,
  // flips the stable state once the disagreement has lasted the full debounce period
  always_comb begin
    kst_d = kst_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (kp_q[i] != kst_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          kst_d[i] = kp_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      kst_q <= '0;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      kst_q <= kst_d;
      for (int i = 0; i < 4; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  assign kst = kst_q;
`else
  assign kst = kp_q;
`endif

  // ---------------------------------------------------------------------------
  // Command decode, tick generator, pattern state and LED drive
  // ---------------------------------------------------------------------------
  logic [3:0]       kst_prev_q;
  logic [3:0]       ev;
  logic             active;
  logic             tick;
  logic             reload;

  mode_e            mode_q;
  mode_e            mode_d;
  logic             run_q;
  logic             run_d;
  logic             dir_q;
  logic             dir_d;
  logic [TickW-1:0] tick_cnt_q;
  logic [TickW-1:0] tick_cnt_d;
  logic [7:0]       rot_q;
  logic [7:0]       rot_d;
  logic             phase_q;
  logic             phase_d;
  logic [7:0]       cnt_q;
  logic [7:0]       cnt_d;
  logic [7:0]       led_q;
  logic [7:0]       led_d;

  // Press events only; releases are ignored
  assign ev     = kst & ~kst_prev_q;
  assign active = run_q && (mode_q != StStatic);
  assign tick   = active && (tick_cnt_q == TickLast);
  // Mode change or key 3 restarts the pattern; this also swallows a same-cycle tick
  assign reload = ev[0] | ev[3];

  // Next-state for mode, run/dir flags, tick counter, pattern registers and LED drive
  always_comb begin
    mode_d     = mode_q;
    run_d      = run_q;
    dir_d      = dir_q;
    tick_cnt_d = tick_cnt_q;
    rot_d      = rot_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    led_d      = led_q;

    if (ev[0]) begin
      unique case (mode_q)
        StStatic: mode_d = StRun;
        StRun:    mode_d = StBlink;
        StBlink:  mode_d = StCount;
        StCount:  mode_d = StStatic;
      endcase
    end

    // A tick in the same cycle still steps with the old run/dir values
    if (ev[1]) begin
      run_d = ~run_q;
    end
    if (ev[2]) begin
      dir_d = ~dir_q;
    end

    if (reload) begin
      tick_cnt_d = '0;
      rot_d      = 8'h01;
      phase_d    = 1'b0;
      cnt_d      = 8'h00;
    end else if (active) begin
      if (tick) begin
        tick_cnt_d = '0;
        unique case (mode_q)
          StStatic: ;
          StRun:    rot_d   = dir_q ? {rot_q[0], rot_q[7:1]} : {rot_q[6:0], rot_q[7]};
          StBlink:  phase_d = ~phase_q;
          StCount:  cnt_d   = dir_q ? (cnt_q - 8'd1) : (cnt_q + 8'd1);
        endcase
      end else begin
        tick_cnt_d = tick_cnt_q + TickW'(1);
      end
    end

    unique case (mode_q)
      StStatic: led_d = {kst, sw_sync_q};
      StRun:    led_d = rot_q;
      StBlink:  led_d = phase_q ? 8'hFF : 8'h00;
      StCount:  led_d = cnt_q;
    endcase
  end

  // Control and pattern state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      kst_prev_q <= '0;
      mode_q     <= StStatic;
      run_q      <= 1'b1;
      dir_q      <= 1'b0;
      tick_cnt_q <= '0;
      rot_q      <= 8'h01;
      phase_q    <= 1'b0;
      cnt_q      <= 8'h00;
      led_q      <= 8'h00;
    end else begin
      kst_prev_q <= kst;
      mode_q     <= mode_d;
      run_q      <= run_d;
      dir_q      <= dir_d;
      tick_cnt_q <= tick_cnt_d;
      rot_q      <= rot_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      led_q      <= led_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed and random stimulus for led_mode_ctrl, every cycle compared
// against a behavioural model of the key/mode/pattern rules kept in this file.
module tb_led_mode_ctrl;

  localparam int unsigned Deb  = 4;
  localparam int unsigned Tick = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  led_mode_ctrl_if bus ();

  led_mode_ctrl #(
    .DEB_CYCLES    (Deb),
    .TICK_CYCLES   (Tick),
    .KEY_ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: pipelines as delay lines, patterns as position/count integers
  bit [3:0] m_kp1, m_kp2, m_sw1, m_sw2;
  bit [3:0] m_kst, m_kst_prev;
  int       m_streak [4];
  int       m_mode;
  bit       m_run, m_dir, m_phase;
  int       m_pos, m_count, m_since;
  bit [7:0] m_led;

  task automatic model_update();
    bit [3:0] kst_now;
    bit [3:0] ev;
    bit       active, tick, reload;
    if (rst) begin
      m_kp1 = '0; m_kp2 = '0; m_sw1 = '0; m_sw2 = '0;
      m_kst = '0; m_kst_prev = '0;
      for (int i = 0; i < 4; i++) m_streak[i] = 0;
      m_mode = 0; m_run = 1'b1; m_dir = 1'b0; m_phase = 1'b0;
      m_pos = 0; m_count = 0; m_since = 0; m_led = 8'h00;
      return;
    end
`ifdef LED_DEBOUNCE_EN
    kst_now = m_kst;
`else
    kst_now = m_kp2;
`endif
    ev     = kst_now & ~m_kst_prev;
    active = m_run && (m_mode != 0);
    tick   = active && (m_since == Tick - 1);
    reload = ev[0] || ev[3];
    case (m_mode)
      0:       m_led = {kst_now, m_sw2};
      1:       m_led = 8'(1 << m_pos);
      2:       m_led = m_phase ? 8'hFF : 8'h00;
      default: m_led = 8'(m_count);
    endcase
    m_kst_prev = kst_now;
`ifdef LED_DEBOUNCE_EN
    // A change is accepted after Deb+1 consecutive disagreeing samples
    for (int i = 0; i < 4; i++) begin
      if (m_kp2[i] != m_kst[i]) begin
        if (m_streak[i] == Deb) begin
          m_kst[i] = m_kp2[i];
          m_streak[i] = 0;
        end else begin
          m_streak[i]++;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
`endif
    if (reload) begin
      m_pos = 0; m_phase = 1'b0; m_count = 0; m_since = 0;
    end else if (active) begin
      if (tick) begin
        m_since = 0;
        case (m_mode)
          1:       m_pos = m_dir ? (m_pos + 7) % 8 : (m_pos + 1) % 8;
          2:       m_phase = !m_phase;
          default: m_count = m_dir ? (m_count + 255) % 256 : (m_count + 1) % 256;
        endcase
      end else begin
        m_since++;
      end
    end
    if (ev[0]) m_mode = (m_mode + 1) % 4;
    if (ev[1]) m_run = !m_run;
    if (ev[2]) m_dir = !m_dir;
    m_kp2 = m_kp1;
    m_kp1 = ~bus.key;
    m_sw2 = m_sw1;
    m_sw1 = bus.sw;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check8("model_led", bus.led, m_led);
    check2("model_mode", bus.mode, 2'(m_mode));
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int idle);
    bus.key = bus.key & ~mask;
    repeat (hold) cycle();
    bus.key = bus.key | mask;
    repeat (idle) cycle();
  endtask

  task automatic wait_led(input string tag, input logic [7:0] exp, input int bound);
    int n = 0;
    while (bus.led !== exp && n < bound) begin
      cycle();
      n++;
    end
    check8(tag, bus.led, exp);
  endtask

  task automatic wait_change(input string tag, input logic [7:0] exp, input int gap);
    logic [7:0] prev;
    int n = 0;
    prev = bus.led;
    while (bus.led === prev && n < 20) begin
      cycle();
      n++;
    end
    check8(tag, bus.led, exp);
    check_int({tag, "_gap"}, n, gap);
  endtask

  initial begin
    bus.key = 4'hF;
    bus.sw  = 4'hA;
    rst     = 1'b1;
    repeat (3) cycle();
    check8("rst_led", bus.led, 8'h00);
    check2("rst_mode", bus.mode, 2'd0);
    rst = 1'b0;

`ifdef LED_DEBOUNCE_EN
    repeat (6) cycle();
    check8("static_sw", bus.led, 8'h0A);
    bus.key = 4'h7;
    repeat (10) cycle();
    check8("static_key3", bus.led, 8'h8A);
    bus.key = 4'hF;
    repeat (10) cycle();
    check8("static_release", bus.led, 8'h0A);

    // Bouncing key 0: never stable long enough
    for (int i = 0; i < 10; i++) begin
      bus.key[0] = (i % 2 == 1);
      repeat (2) cycle();
    end
    repeat (6) cycle();
    check2("bounce_mode", bus.mode, 2'd0);
    press(4'b0001, 8, 0);
    check2("held_mode", bus.mode, 2'd1);

    // Running light, then direction flip before the 04 -> next step
    cycle();
    check8("run_first", bus.led, 8'h01);
    wait_change("run_02", 8'h02, 5);
    bus.key[2] = 1'b0;
    wait_change("run_04", 8'h04, 5);
    wait_change("run_back_02", 8'h02, 5);
    wait_change("run_back_01", 8'h01, 5);
    wait_change("run_wrap_80", 8'h80, 5);
    check2("run_mode_once", bus.mode, 2'd1);
    bus.key[2] = 1'b1;
    repeat (10) cycle();

    // Back to dir=0, advance to count mode
    press(4'b0100, 8, 10);
    press(4'b0001, 8, 10);
    press(4'b0001, 8, 10);
    check2("count_mode", bus.mode, 2'd3);

    // Pause lands right after the 03 step
    wait_led("cnt_02", 8'h02, 40);
    bus.key[1] = 1'b0;
    wait_led("cnt_03", 8'h03, 10);
    for (int i = 0; i < 20; i++) begin
      cycle();
      check8("pause_hold", bus.led, 8'h03);
    end
    bus.key[1] = 1'b1;
    repeat (10) cycle();
    check8("pause_release", bus.led, 8'h03);
    press(4'b0010, 8, 0);
    wait_led("resume_04", 8'h04, 20);
    press(4'b1000, 8, 0);
    wait_led("restart_00", 8'h00, 20);

    // Direction flip and restart together, then count down from zero
    press(4'b1100, 8, 0);
    wait_led("down_wrap_ff", 8'hFF, 20);

    // Key 0 event lands in the same cycle as a tick
    cycle();
    bus.key[0] = 1'b0;
    repeat (8) cycle();
    check2("collide_mode", bus.mode, 2'd0);
    bus.key[0] = 1'b1;
    cycle();
    check8("collide_led", bus.led, 8'h1A);
`else
    repeat (4) cycle();
    bus.key = 4'hE;
    cycle();
    check2("pulse_mode_c1", bus.mode, 2'd0);
    bus.key = 4'hF;
    cycle();
    check2("pulse_mode_c2", bus.mode, 2'd0);
    cycle();
    check2("pulse_mode_c3", bus.mode, 2'd1);
    cycle();
    check8("pulse_led", bus.led, 8'h01);
`endif

    // Random keys, switches and occasional resets against the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 3)) cycle();
        rst = 1'b0;
      end
      bus.key = ~(4'($urandom) & 4'($urandom));
      bus.sw  = 4'($urandom);
      repeat ($urandom_range(1, 12)) cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
